// File: rtl/fp_stream_accumulator.sv
// Streaming IEEE-754 single-precision sum: one element per cycle folded into acc_q
// through a combinational float_add, result handed off over a valid/ready port.

module float_add (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);
    logic        a_nan, b_nan, a_inf, b_inf, swap, eff_sub, found;
    logic [31:0] big, sml;
    logic [7:0]  e_big, e_sml, d, ef;
    logic [26:0] m_big, m_sml, m_sh, norm;
    logic [27:0] sum;
    logic [4:0]  lz, sh;
    logic [9:0]  e_n;
    logic [24:0] rnd;
    logic [22:0] frac;

    always_comb begin
        a_nan = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
        b_nan = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
        a_inf = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'd0);
        b_inf = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'd0);

        // Order by magnitude so the alignment shift and subtraction never go negative.
        swap    = a_i[30:0] < b_i[30:0];
        big     = swap ? b_i : a_i;
        sml     = swap ? a_i : b_i;
        eff_sub = a_i[31] ^ b_i[31];
        e_big   = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
        e_sml   = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
        m_big   = {big[30:23] != 8'd0, big[22:0], 3'b000};
        m_sml   = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
        d       = e_big - e_sml;

        if (d >= 8'd27) begin
            m_sh = {26'd0, |m_sml};
        end else begin
            m_sh    = m_sml >> d;
            m_sh[0] = m_sh[0] | (|(m_sml & ((27'd1 << d) - 27'd1)));
        end

        sum = eff_sub ? ({1'b0, m_big} - {1'b0, m_sh}) : ({1'b0, m_big} + {1'b0, m_sh});

        lz    = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end

        // Left shift is capped so the exponent bottoms out at 1 (denormal result).
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            e_n  = {2'b00, e_big} + 10'd1;
            sh   = 5'd0;
        end else begin
            sh   = ({3'b000, lz} < (e_big - 8'd1)) ? lz : 5'(e_big - 8'd1);
            norm = sum[26:0] << sh;
            e_n  = {2'b00, e_big} - {5'd0, sh};
        end

        rnd = {1'b0, norm[26:3]} + {24'd0, norm[2] & (norm[1] | norm[0] | norm[3])};
        if (rnd[24]) begin
            ef   = (e_n >= 10'd254) ? 8'hFF : 8'(e_n + 10'd1);
            frac = rnd[23:1];
        end else begin
            ef   = rnd[23] ? ((e_n >= 10'd255) ? 8'hFF : e_n[7:0]) : 8'd0;
            frac = rnd[22:0];
        end

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) y_o = 32'h7FC00000;
        else if (a_inf)                                    y_o = a_i;
        else if (b_inf)                                    y_o = b_i;
        else if (sum == 28'd0)                             y_o = {a_i[31] & b_i[31], 31'd0};
        else if (ef == 8'hFF)                              y_o = {big[31], 8'hFF, 23'd0};
        else                                               y_o = {big[31], ef, frac};
    end
endmodule

module fp_stream_accumulator #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             in_valid_i,
    input  logic [31:0]      in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [31:0]      out_data_o,
    output logic             out_ovf_o,
    input  logic             out_ready_i,
    output logic             busy_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      acc_q, acc_d, sum;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d, xfer;

    float_add u_add (
        .a_i (acc_q),
        .b_i (in_data_i),
        .y_o (sum)
    );

    assign in_ready_o  = (state_q == ACCUM);
    assign out_valid_o = (state_q == DONE);
    assign out_data_o  = acc_q;
    assign out_ovf_o   = ovf_q;
    assign busy_o      = (state_q != IDLE);
    assign xfer        = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start_i) begin
                acc_d   = 32'h0;
                ovf_d   = 1'b0;
                rem_d   = len_i;
                state_d = (len_i != '0) ? ACCUM : DONE;
            end
            ACCUM: if (xfer) begin
                acc_d = sum;
                rem_d = rem_q - 1'b1;
                ovf_d = ovf_q | (in_data_i[30:23] == 8'hFF) | (sum[30:23] == 8'hFF);
                if (rem_q == LEN_W'(1)) state_d = DONE;
            end
            DONE: if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 32'h0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Directed bench for fp_stream_accumulator; inputs change and outputs are checked on negedge.

module tb_fp_stream_accumulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  len_i = 8'd0;
    logic        in_valid_i = 1'b0;
    logic [31:0] in_data_i = 32'd0;
    logic        in_ready_o, out_valid_o, out_ovf_o, busy_o;
    logic [31:0] out_data_o;
    logic        out_ready_i = 1'b0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    fp_stream_accumulator #(.LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ovf_o(out_ovf_o),
        .out_ready_i(out_ready_i), .busy_o(busy_o)
    );

    task automatic test_reset();
        #1;
        tests++;
        if ({in_ready_o, out_valid_o, out_ovf_o, busy_o, out_data_o} !== 36'd0) begin
            fails++;
            $display("FAIL reset_outputs got rdy=%b vld=%b ovf=%b busy=%b data=%h exp all 0",
                     in_ready_o, out_valid_o, out_ovf_o, busy_o, out_data_o);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] v [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        start_i = 1'b1; len_i = 8'd4;
        @(negedge clk) start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL basic_accum[%0d] got rdy=%b vld=%b exp rdy=1 vld=0", i, in_ready_o, out_valid_o);
            end
            in_valid_i = 1'b1; in_data_i = v[i];
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        tests++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h41200000 || out_ovf_o !== 1'b0 || in_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL basic_sum got vld=%b data=%h ovf=%b rdy=%b exp vld=1 data=41200000 ovf=0 rdy=0",
                     out_valid_o, out_data_o, out_ovf_o, in_ready_o);
        end
        out_ready_i = 1'b1;
        @(negedge clk) out_ready_i = 1'b0;
        tests++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle got vld=%b busy=%b exp 0 0", out_valid_o, busy_o);
        end
    endtask

    task automatic test_zero_len();
        start_i = 1'b1; len_i = 8'd0;
        @(negedge clk) start_i = 1'b0;
        tests++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h0 || in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL zero_len got vld=%b data=%h rdy=%b busy=%b exp vld=1 data=00000000 rdy=0 busy=1",
                     out_valid_o, out_data_o, in_ready_o, busy_o);
        end
        out_ready_i = 1'b1;
        @(negedge clk) out_ready_i = 1'b0;
        tests++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL zero_len_idle got vld=%b rdy=%b exp 0 0", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_bubbles();
        logic [31:0] v [3] = '{32'h3FC00000, 32'h3FA00000, 32'hC0000000};
        start_i = 1'b1; len_i = 8'd3;
        @(negedge clk) start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; in_data_i = v[i];
            @(negedge clk) in_valid_i = 1'b0;
            if (i < 2) begin
                for (int b = 0; b < 2; b++) begin
                    tests++;
                    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || busy_o !== 1'b1) begin
                        fails++;
                        $display("FAIL bubble_hold[%0d.%0d] got vld=%b rdy=%b busy=%b exp 0 1 1",
                                 i, b, out_valid_o, in_ready_o, busy_o);
                    end
                    @(negedge clk);
                end
            end
        end
        tests++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h3F400000 || out_ovf_o !== 1'b0) begin
            fails++;
            $display("FAIL bubble_sum got vld=%b data=%h ovf=%b exp vld=1 data=3F400000 ovf=0",
                     out_valid_o, out_data_o, out_ovf_o);
        end
        out_ready_i = 1'b1;
        @(negedge clk) out_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        start_i = 1'b1; len_i = 8'd2;
        @(negedge clk) start_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'h3F800000;
        @(negedge clk) start_i = 1'b1; len_i = 8'd5;
        @(negedge clk) in_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (out_valid_o !== 1'b1 || out_data_o !== 32'h40000000) begin
                fails++;
                $display("FAIL stall_hold[%0d] got vld=%b data=%h exp vld=1 data=40000000", c, out_valid_o, out_data_o);
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk) out_ready_i = 1'b0;
        tests++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL stall_release got vld=%b busy=%b exp 0 0", out_valid_o, busy_o);
        end
    endtask

    task automatic test_ovf();
        start_i = 1'b1; len_i = 8'd2;
        @(negedge clk) start_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'h7F800000;
        @(negedge clk) in_data_i = 32'h3F800000;
        @(negedge clk) in_valid_i = 1'b0;
        tests++;
        if (out_valid_o !== 1'b1 || out_ovf_o !== 1'b1 || out_data_o !== 32'h7F800000) begin
            fails++;
            $display("FAIL ovf_set got vld=%b ovf=%b data=%h exp vld=1 ovf=1 data=7F800000",
                     out_valid_o, out_ovf_o, out_data_o);
        end
        out_ready_i = 1'b1;
        @(negedge clk) out_ready_i = 1'b0;
        start_i = 1'b1; len_i = 8'd1;
        tests++;
        if (out_ovf_o !== 1'b1 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL ovf_sticky_idle got ovf=%b busy=%b exp ovf=1 busy=0", out_ovf_o, busy_o);
        end
        @(negedge clk) start_i = 1'b0;
        tests++;
        if (out_ovf_o !== 1'b0 || busy_o !== 1'b1 || in_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL ovf_cleared got ovf=%b busy=%b rdy=%b exp 0 1 1", out_ovf_o, busy_o, in_ready_o);
        end
        in_valid_i = 1'b1; in_data_i = 32'h3F800000;
        @(negedge clk) in_valid_i = 1'b0;
        tests++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h3F800000 || out_ovf_o !== 1'b0) begin
            fails++;
            $display("FAIL ovf_rerun got vld=%b data=%h ovf=%b exp vld=1 data=3F800000 ovf=0",
                     out_valid_o, out_data_o, out_ovf_o);
        end
        out_ready_i = 1'b1;
        @(negedge clk) out_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        start_i = 1'b1; len_i = 8'd4;
        @(negedge clk) start_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'h40000000;
        @(negedge clk);
        @(negedge clk) in_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready_o, out_valid_o, out_ovf_o, busy_o, out_data_o} !== 36'd0) begin
            fails++;
            $display("FAIL reset_mid got rdy=%b vld=%b ovf=%b busy=%b data=%h exp all 0",
                     in_ready_o, out_valid_o, out_ovf_o, busy_o, out_data_o);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) start_i = 1'b1; len_i = 8'd1;
        @(negedge clk) start_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 32'h40A00000;
        @(negedge clk) in_valid_i = 1'b0;
        tests++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h40A00000 || out_ovf_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_rerun got vld=%b data=%h ovf=%b exp vld=1 data=40A00000 ovf=0",
                     out_valid_o, out_data_o, out_ovf_o);
        end
        out_ready_i = 1'b1;
        @(negedge clk) out_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_bubbles();
        test_backpressure();
        test_ovf();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
